// File: rtl/mux_scan_sequencer_if.sv
// Bus between the scan sequencer and whoever requests scans and supplies the
// mux output. The sequencer is the slave side; the requester/mux is master.
interface mux_scan_sequencer_if #(
    parameter int NUM_CH = 7,
    parameter int SEL_W  = 3
);
    logic              start;
    logic              continuous;
    logic [NUM_CH-1:0] mask;
    logic              y_in;
    logic [SEL_W-1:0]  sel;
    logic              busy;
    logic              done;
    logic [NUM_CH-1:0] sample;

    modport master (
        output start, continuous, mask, y_in,
        input  sel, busy, done, sample
    );

    modport slave (
        input  start, continuous, mask, y_in,
        output sel, busy, done, sample
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps the 7:1 mux select through every enabled channel in ascending order,
// waits DWELL cycles on each, samples the mux output and publishes the
// assembled word with a busy/done handshake.
module mux_scan_sequencer #(
    parameter int NUM_CH = 7,
    parameter int DWELL  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_scan_sequencer_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_CH);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_FINISH} state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NUM_CH-1:0] sample_q, sample_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] shadow_ins;
    logic [NUM_CH-1:0] above;

    // Index of the lowest set bit; callers only use it on non-zero vectors.
    function automatic logic [SEL_W-1:0] lowest(input logic [NUM_CH-1:0] v);
        lowest = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (v[i]) lowest = SEL_W'(i);
    endfunction

    // Next-state and next-output logic; defaults hold everything except done.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sample_d = sample_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;

        // Shadow word with the current channel's bit written in, so the final
        // sample can be published in the same edge it is taken.
        shadow_ins        = shadow_q;
        shadow_ins[sel_q] = bus.y_in;

        // Enabled channels strictly above the current one.
        above = '0;
        for (int i = 0; i < NUM_CH; i++)
            above[i] = mask_q[i] && (i > int'(sel_q));

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mask_d   = bus.mask;
                    shadow_d = '0;
                    if (|bus.mask) begin
                        sel_d   = lowest(bus.mask);
                        cnt_d   = RELOAD;
                        busy_d  = 1'b1;
                        state_d = S_DWELL;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_DWELL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shadow_d = shadow_ins;
                    if (|above) begin
                        sel_d = lowest(above);
                        cnt_d = RELOAD;
                    end else begin
                        sample_d = shadow_ins;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = S_IDLE;
                        // Back-to-back scans: restart without leaving DWELL.
                        if (bus.continuous) begin
                            mask_d   = bus.mask;
                            shadow_d = '0;
                            if (|bus.mask) begin
                                sel_d   = lowest(bus.mask);
                                cnt_d   = RELOAD;
                                busy_d  = 1'b1;
                                state_d = S_DWELL;
                            end else begin
                                state_d = S_FINISH;
                            end
                        end
                    end
                end
            end
            S_FINISH: begin
                sample_d = '0;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any scan and discards the partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sample_q <= '0;
            shadow_q <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sample_q <= sample_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
        end
    end

    assign bus.sel    = sel_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.sample = sample_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: one DWELL=2 instance for single scans and one
// DWELL=1 instance for continuous mode. Expected words go into a queue when a
// scan is launched and are popped when done is seen.
module tb_mux_scan_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_scan_sequencer_if b2 ();
    mux_scan_sequencer_if b1 ();

    mux_scan_sequencer #(.NUM_CH(7), .DWELL(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
    mux_scan_sequencer #(.NUM_CH(7), .DWELL(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    // Behavioural 7:1 mux in front of each sequencer.
    logic [6:0] ipat2 = 7'h00;
    logic [6:0] ipat1 = 7'h00;
    assign b2.y_in = ipat2[b2.sel];
    assign b1.y_in = ipat1[b1.sel];

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];
    logic [6:0] exp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp();
        if (exp_q.size() == 0) begin
            exp = 7'hxx;
            errors++;
            $display("FAIL scoreboard: done seen with no expected word queued");
        end else begin
            exp = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (b2.sel !== 3'd0 || b2.busy !== 1'b0 || b2.done !== 1'b0 || b2.sample !== 7'h00) begin
            errors++;
            $display("FAIL reset_state: sel=%0d busy=%b done=%b sample=%h want 0/0/0/00",
                     b2.sel, b2.busy, b2.done, b2.sample);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (b1.sel !== 3'd0 || b1.busy !== 1'b0 || b1.done !== 1'b0 || b1.sample !== 7'h00) begin
            errors++;
            $display("FAIL reset_release: sel=%0d busy=%b done=%b sample=%h want 0/0/0/00",
                     b1.sel, b1.busy, b1.done, b1.sample);
        end
    endtask

    // One DWELL=2 scan: sel walks the enabled channels every 2 edges and the
    // word appears with done right after edge 2*K.
    task automatic test_scan(input string nm, input logic [6:0] m, input logic [6:0] pat);
        int ch[$];
        int k;
        for (int i = 0; i < 7; i++) if (m[i]) ch.push_back(i);
        k = ch.size();
        ipat2 = pat;
        b2.mask = m;
        exp_q.push_back(m & pat);
        b2.start = 1'b1;
        tick();
        b2.start = 1'b0;
        checks++;
        if (b2.sel !== 3'(ch[0]) || b2.busy !== 1'b1 || b2.done !== 1'b0) begin
            errors++;
            $display("FAIL %s_launch: sel=%0d busy=%b done=%b want %0d/1/0", nm, b2.sel, b2.busy, b2.done, ch[0]);
        end
        for (int e = 1; e <= 2 * k; e++) begin
            tick();
            checks++;
            if (e < 2 * k) begin
                if (b2.sel !== 3'(ch[e / 2]) || b2.busy !== 1'b1 || b2.done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_edge%0d: sel=%0d busy=%b done=%b want %0d/1/0",
                             nm, e, b2.sel, b2.busy, b2.done, ch[e / 2]);
                end
            end else begin
                pop_exp();
                if (b2.done !== 1'b1 || b2.busy !== 1'b0 || b2.sample !== exp || b2.sel !== 3'(ch[k - 1])) begin
                    errors++;
                    $display("FAIL %s_done: done=%b busy=%b sample=%h sel=%0d want 1/0/%h/%0d",
                             nm, b2.done, b2.busy, b2.sample, b2.sel, exp, ch[k - 1]);
                end
            end
        end
        tick();
        checks++;
        if (b2.done !== 1'b0 || b2.sample !== exp || b2.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: done=%b sample=%h busy=%b want 0/%h/0", nm, b2.done, b2.sample, b2.busy, exp);
        end
    endtask

    task automatic test_empty_mask();
        logic [2:0] sel0;
        int ndone = 0;
        int nbusy = 0;
        sel0 = b2.sel;
        b2.mask = 7'h00;
        exp_q.push_back(7'h00);
        b2.start = 1'b1;
        tick();
        b2.start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (b2.busy !== 1'b0 || b2.sel !== sel0) nbusy++;
            if (b2.done === 1'b1) begin
                ndone++;
                pop_exp();
                checks++;
                if (b2.sample !== exp) begin
                    errors++;
                    $display("FAIL empty_sample: sample=%h want %h", b2.sample, exp);
                end
            end
            tick();
        end
        checks++;
        if (ndone != 1 || nbusy != 0) begin
            errors++;
            $display("FAIL empty_handshake: done_cycles=%0d busy_or_sel_moves=%0d want 1/0", ndone, nbusy);
        end
    endtask

    task automatic test_start_during_busy();
        int ndone = 0;
        int done_edge = -1;
        ipat2 = 7'b0110110;
        b2.mask = 7'h7F;
        exp_q.push_back(7'h7F & 7'b0110110);
        b2.start = 1'b1;
        tick();
        b2.start = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            if (e == 3) begin
                b2.start = 1'b1;
                b2.mask  = 7'h01;
            end
            if (e == 6) b2.start = 1'b0;
            tick();
            if (b2.done === 1'b1) begin
                ndone++;
                if (done_edge < 0) done_edge = e;
                pop_exp();
                checks++;
                if (b2.sample !== exp) begin
                    errors++;
                    $display("FAIL busy_start_sample: sample=%h want %h", b2.sample, exp);
                end
            end
        end
        checks++;
        if (ndone != 1 || done_edge != 14) begin
            errors++;
            $display("FAIL busy_start_done: count=%0d edge=%0d want 1/14", ndone, done_edge);
        end
    endtask

    task automatic test_reset_mid_scan();
        int ndone = 0;
        ipat2 = 7'b1010011;
        b2.mask = 7'h7F;
        b2.start = 1'b1;
        tick();
        b2.start = 1'b0;
        for (int e = 0; e < 5; e++) tick();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (b2.sel !== 3'd0 || b2.busy !== 1'b0 || b2.done !== 1'b0 || b2.sample !== 7'h00) begin
            errors++;
            $display("FAIL reset_mid_scan: sel=%0d busy=%b done=%b sample=%h want 0/0/0/00",
                     b2.sel, b2.busy, b2.done, b2.sample);
        end
        tick();
        rst = 1'b0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (b2.done === 1'b1 || b2.busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL reset_no_done: done_or_busy_cycles=%0d want 0", ndone);
        end
    endtask

    // DWELL=1, two channels: a done every other edge while continuous is held.
    task automatic test_continuous();
        int quiet = 0;
        ipat1 = 7'b0000010;
        b1.mask = 7'h03;
        b1.continuous = 1'b1;
        exp_q.push_back(7'h03 & 7'b0000010);
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        checks++;
        if (b1.sel !== 3'd0 || b1.busy !== 1'b1) begin
            errors++;
            $display("FAIL cont_launch: sel=%0d busy=%b want 0/1", b1.sel, b1.busy);
        end
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (e % 2 == 1) begin
                if (b1.sel !== 3'd1 || b1.busy !== 1'b1 || b1.done !== 1'b0) begin
                    errors++;
                    $display("FAIL cont_edge%0d: sel=%0d busy=%b done=%b want 1/1/0", e, b1.sel, b1.busy, b1.done);
                end
                if (e == 7) b1.continuous = 1'b0;
            end else begin
                pop_exp();
                if (b1.done !== 1'b1 || b1.sample !== exp) begin
                    errors++;
                    $display("FAIL cont_done%0d: done=%b sample=%h want 1/%h", e, b1.done, b1.sample, exp);
                end
                checks++;
                if (e < 8) begin
                    exp_q.push_back(7'h03 & ipat1);
                    if (b1.sel !== 3'd0 || b1.busy !== 1'b1) begin
                        errors++;
                        $display("FAIL cont_restart%0d: sel=%0d busy=%b want 0/1", e, b1.sel, b1.busy);
                    end
                end else if (b1.sel !== 3'd1 || b1.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL cont_stop: sel=%0d busy=%b want 1/0", b1.sel, b1.busy);
                end
            end
        end
        for (int e = 0; e < 4; e++) begin
            tick();
            if (b1.done !== 1'b0 || b1.busy !== 1'b0) quiet++;
        end
        checks++;
        if (quiet != 0) begin
            errors++;
            $display("FAIL cont_idle: active_cycles=%0d want 0", quiet);
        end
    endtask

    initial begin
        b2.start = 1'b0; b2.continuous = 1'b0; b2.mask = 7'h00;
        b1.start = 1'b0; b1.continuous = 1'b0; b1.mask = 7'h00;
        test_reset();
        test_scan("full", 7'h7F, 7'b1010011);
        test_scan("sparse", 7'b1000101, 7'h7F);
        test_empty_mask();
        test_start_during_busy();
        test_reset_mid_scan();
        test_continuous();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d words never produced", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
